usb_trans_ctrl: RTL and testbench
=================================

Name: usb_trans_ctrl

Overview:
Device-side USB transaction sequencer between the packet receiver and packet transmitter of the full-speed serial interface engine. It consumes decoded token and data packets, filters them by device address and endpoint, and decides the response: DATAx, ACK, NAK, STALL or silence. It owns the per-endpoint data-toggle bits and the turnaround timeouts. Endpoint buffers provide only ready/stall status and receive commit/retry pulses.

Parameters:
N_ENDP, 4, number of endpoints implemented (1..16); endpoint indices >= N_ENDP are ignored.
TIMEOUT_CYC, 18*4, clk_i cycles allowed between end of token/data packet and the expected next packet.

Ports:
clk_i  in  1  system clock, 4x full-speed bit rate.
rst_i  in  1  synchronous, active-high reset.
dev_addr_i  in  7  assigned device address.
rx_valid_i  in  1  one-cycle pulse: packet received with good CRC; rx_pid/addr/endp valid this cycle.
rx_err_i  in  1  one-cycle pulse: packet received with CRC/bitstuff/PID-check error.
rx_pid_i  in  4  received PID.
rx_addr_i  in  7  token address field.
rx_endp_i  in  4  token endpoint field.
in_ready_i  in  N_ENDP  endpoint has an IN packet queued.
out_ready_i  in  N_ENDP  endpoint has space for an OUT packet.
stall_i  in  N_ENDP  endpoint halted.
tx_req_o  out  1  request transmitter to send tx_pid_o; held high until tx_done_i.
tx_pid_o  out  4  PID to transmit.
tx_endp_o  out  4  endpoint whose buffer supplies DATAx payload.
tx_done_i  in  1  one-cycle pulse: transmitted packet finished (EOP sent).
endp_o  out  4  endpoint of the current transaction.
in_ack_o  out  1  pulse: IN packet on endp_o acknowledged; buffer may release it.
in_retry_o  out  1  pulse: IN packet not acknowledged; buffer must rewind.
out_commit_o  out  1  pulse: OUT/SETUP data on endp_o accepted.
out_discard_o  out  1  pulse: received OUT/SETUP data on endp_o must be dropped.
setup_o  out  1  pulse coincident with out_commit_o for SETUP transactions.

Behaviour:
- PID codes: OUT=1, IN=9, SOF=5, SETUP=D, DATA0=3, DATA1=B, ACK=2, NAK=A, STALL=E.
- Reset: state IDLE; all outputs 0; all IN and OUT toggles 0; timeout counter 0. Reset mid-transaction aborts without any pulse, and tx_req_o drops in the same cycle as reset is sampled.
- Token match: rx_valid_i, PID in {OUT, IN, SETUP}, rx_addr_i == dev_addr_i and rx_endp_i < N_ENDP. Otherwise the token is ignored. SOF is always ignored. endp_o latches rx_endp_i on a match.
- States: IDLE, WAIT_DATA, TX_HS, TX_DATA, WAIT_ACK.
- IDLE, IN match:
  - If stall: TX_HS with STALL.
  - Else if in_ready == 0: TX_HS with NAK.
  - Else: TX_DATA with tx_pid = in_toggle ? DATA1 : DATA0 and tx_endp = endp.
- IDLE, OUT/SETUP match: go to WAIT_DATA, load timeout, and remember whether the token was SETUP.
- tx_req_o asserts the cycle after the decision. It stays high with tx_pid_o/tx_endp_o stable until tx_done_i, then deasserts the next cycle.
- TX_HS with tx_done_i: go to IDLE.
- TX_DATA with tx_done_i: go to WAIT_ACK and load timeout.
- WAIT_ACK:
  - rx_valid_i with PID ACK: in_ack_o pulse, flip in_toggle[endp], go to IDLE.
  - Any other rx_valid_i, rx_err_i or timeout expiry: in_retry_o pulse, toggle unchanged, go to IDLE.
- WAIT_DATA:
  - rx_valid_i with DATA0/1, SETUP token: always ACK, ignoring stall and out_ready. Set in_toggle[endp] = out_toggle[endp] = 1, pulse out_commit_o and setup_o, go to TX_HS with ACK.
  - DATA0/1 after OUT, stall: out_discard_o pulse, TX_HS with STALL.
  - DATA0/1 after OUT, !out_ready: out_discard_o pulse, TX_HS with NAK.
  - DATA0/1 after OUT, data PID mismatches out_toggle (retransmission): out_discard_o pulse, TX_HS with ACK, toggle unchanged.
  - DATA0/1 after OUT, otherwise: out_commit_o pulse, flip out_toggle, TX_HS with ACK.
  - rx_err_i, non-DATA rx_valid_i (including a new token) or timeout: out_discard_o pulse, IDLE, no transmission. The token is dropped, not reprocessed.
- Timeout counter: loaded with TIMEOUT_CYC on state entry and decremented each cycle. Expiry is the cycle it reaches 0 without a qualifying rx event; an rx event in the expiry cycle takes priority.
- rx events arriving in TX_HS/TX_DATA are ignored.
- All pulses are exactly one cycle. At most one of in_ack/in_retry/out_commit/out_discard fires per transaction.

Test Plan:
- Reset, then IN to addr 5 ep1 with dev_addr=5, in_ready[1]=1 -> tx_req with tx_pid=3 (DATA0), tx_endp=1. After tx_done and rx ACK -> in_ack_o pulse. Next IN -> tx_pid=B.
- IN ep1, DATA0 sent, no ACK for TIMEOUT_CYC -> in_retry_o pulse, no toggle change, next IN again sends DATA0. IN with stall_i[1]=1 -> tx_pid=E.
- OUT ep2 + DATA0, out_ready=1 -> out_commit_o pulse and ACK (2). Repeat DATA0 -> out_discard_o pulse and ACK. Then DATA1 -> out_commit_o.
- SETUP ep0 + DATA0 with stall_i[0]=1 -> ACK, setup_o and out_commit_o pulses. Following IN ep0 sends DATA1.
- Token for addr 6 when dev_addr=5, token for ep >= N_ENDP, and SOF -> no tx_req_o, no pulses. OUT followed by rx_err_i -> out_discard_o pulse, no tx_req_o.
- rst_i asserted while tx_req_o is high in TX_DATA -> tx_req_o low the next cycle, no pulses, toggles reset so the following IN sends DATA0.

Source files
------------

// File: rtl/usb_trans_ctrl_if.sv
// Signal bundle between the USB transaction sequencer and its surroundings:
// packet receiver, packet transmitter and endpoint buffer status/commit lines.
// The slave modport is the sequencer's view; the master modport is the view of
// whatever drives it (receiver/transmitter/buffers, or a testbench).
interface usb_trans_ctrl_if #(
  parameter int N_ENDP = 4
);
  // Device configuration
  logic [6:0]        dev_addr_i;
  // Packet receiver
  logic              rx_valid_i;
  logic              rx_err_i;
  logic [3:0]        rx_pid_i;
  logic [6:0]        rx_addr_i;
  logic [3:0]        rx_endp_i;
  // Endpoint buffer status
  logic [N_ENDP-1:0] in_ready_i;
  logic [N_ENDP-1:0] out_ready_i;
  logic [N_ENDP-1:0] stall_i;
  // Packet transmitter
  logic              tx_req_o;
  logic [3:0]        tx_pid_o;
  logic [3:0]        tx_endp_o;
  logic              tx_done_i;
  // Endpoint buffer commit/retry strobes
  logic [3:0]        endp_o;
  logic              in_ack_o;
  logic              in_retry_o;
  logic              out_commit_o;
  logic              out_discard_o;
  logic              setup_o;

  modport slave (
    input  dev_addr_i, rx_valid_i, rx_err_i, rx_pid_i, rx_addr_i, rx_endp_i,
    input  in_ready_i, out_ready_i, stall_i, tx_done_i,
    output tx_req_o, tx_pid_o, tx_endp_o,
    output endp_o, in_ack_o, in_retry_o, out_commit_o, out_discard_o, setup_o
  );

  modport master (
    output dev_addr_i, rx_valid_i, rx_err_i, rx_pid_i, rx_addr_i, rx_endp_i,
    output in_ready_i, out_ready_i, stall_i, tx_done_i,
    input  tx_req_o, tx_pid_o, tx_endp_o,
    input  endp_o, in_ack_o, in_retry_o, out_commit_o, out_discard_o, setup_o
  );
endinterface

// File: rtl/usb_trans_ctrl.sv
// Device-side USB full-speed transaction sequencer. Filters decoded tokens by
// address/endpoint, chooses the response (DATAx, ACK, NAK, STALL or silence),
// owns the per-endpoint IN/OUT data toggles and the turnaround timeouts, and
// strobes the endpoint buffers to commit, discard, release or rewind.
module usb_trans_ctrl #(
  parameter int N_ENDP      = 4,
  parameter int TIMEOUT_CYC = 18 * 4
) (
  input logic            clk_i,
  input logic            rst_i,
  usb_trans_ctrl_if.slave bus
);

  // Endpoint index width; N_ENDP is at most 16 so this never exceeds 4 bits.
  localparam int EW = (N_ENDP > 1) ? $clog2(N_ENDP) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    TX_HS,
    TX_DATA,
    WAIT_ACK
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic              is_setup;
  logic [N_ENDP-1:0] in_tog;
  logic [N_ENDP-1:0] out_tog;

  logic              tx_req;
  logic [3:0]        tx_pid;
  logic [3:0]        tx_endp;
  logic [3:0]        endp;
  logic              in_ack;
  logic              in_retry;
  logic              out_commit;
  logic              out_discard;
  logic              setup;

  // Decoded view of the receiver inputs.
  logic [EW-1:0] rx_idx;
  logic [EW-1:0] cur_idx;
  logic          token_match;
  logic          rx_is_data;
  logic          rx_data_bit;
  logic          rx_is_ack;
  logic          rx_event;
  logic          expired;

  assign rx_idx      = bus.rx_endp_i[EW-1:0];
  assign cur_idx     = endp[EW-1:0];
  assign token_match = bus.rx_valid_i
                     && (bus.rx_pid_i == PID_OUT || bus.rx_pid_i == PID_IN
                         || bus.rx_pid_i == PID_SETUP)
                     && (bus.rx_addr_i == bus.dev_addr_i)
                     && (int'(bus.rx_endp_i) < N_ENDP);
  assign rx_is_data  = bus.rx_valid_i
                     && (bus.rx_pid_i == PID_DATA0 || bus.rx_pid_i == PID_DATA1);
  assign rx_data_bit = (bus.rx_pid_i == PID_DATA1);
  assign rx_is_ack   = bus.rx_valid_i && (bus.rx_pid_i == PID_ACK);
  assign rx_event    = bus.rx_valid_i || bus.rx_err_i;
  assign expired     = (timer == '0);

  // Transaction FSM: state, toggles, timeout counter and all registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order in this block.
    if (rst_i) begin
      state       <= IDLE;
      timer       <= '0;
      is_setup    <= 1'b0;
      in_tog      <= '0;
      out_tog     <= '0;
      tx_req      <= 1'b0;
      tx_pid      <= 4'h0;
      tx_endp     <= 4'h0;
      endp        <= 4'h0;
      in_ack      <= 1'b0;
      in_retry    <= 1'b0;
      out_commit  <= 1'b0;
      out_discard <= 1'b0;
      setup       <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      in_ack      <= 1'b0;
      in_retry    <= 1'b0;
      out_commit  <= 1'b0;
      out_discard <= 1'b0;
      setup       <= 1'b0;

      case (state)
        IDLE: begin
          if (token_match) begin
            endp    <= bus.rx_endp_i;
            tx_endp <= bus.rx_endp_i;
            if (bus.rx_pid_i == PID_IN) begin
              tx_req <= 1'b1;
              if (bus.stall_i[rx_idx]) begin
                state  <= TX_HS;
                tx_pid <= PID_STALL;
              end else if (!bus.in_ready_i[rx_idx]) begin
                state  <= TX_HS;
                tx_pid <= PID_NAK;
              end else begin
                state  <= TX_DATA;
                tx_pid <= in_tog[rx_idx] ? PID_DATA1 : PID_DATA0;
              end
            end else begin
              state    <= WAIT_DATA;
              timer    <= TW'(TIMEOUT_CYC);
              is_setup <= (bus.rx_pid_i == PID_SETUP);
            end
          end
        end

        WAIT_DATA: begin
          if (rx_is_data) begin
            state  <= TX_HS;
            tx_req <= 1'b1;
            tx_pid <= PID_ACK;
            if (is_setup) begin
              // SETUP is always accepted and resynchronises both toggles.
              in_tog[cur_idx]  <= 1'b1;
              out_tog[cur_idx] <= 1'b1;
              out_commit       <= 1'b1;
              setup            <= 1'b1;
            end else if (bus.stall_i[cur_idx]) begin
              out_discard <= 1'b1;
              tx_pid      <= PID_STALL;
            end else if (!bus.out_ready_i[cur_idx]) begin
              out_discard <= 1'b1;
              tx_pid      <= PID_NAK;
            end else if (rx_data_bit != out_tog[cur_idx]) begin
              // Host missed our last ACK and resent: acknowledge, keep nothing.
              out_discard <= 1'b1;
            end else begin
              out_commit       <= 1'b1;
              out_tog[cur_idx] <= ~out_tog[cur_idx];
            end
          end else if (rx_event || expired) begin
            out_discard <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        TX_HS: begin
          if (bus.tx_done_i) begin
            tx_req <= 1'b0;
            state  <= IDLE;
          end
        end

        TX_DATA: begin
          if (bus.tx_done_i) begin
            tx_req <= 1'b0;
            state  <= WAIT_ACK;
            timer  <= TW'(TIMEOUT_CYC);
          end
        end

        WAIT_ACK: begin
          if (rx_is_ack) begin
            in_ack          <= 1'b1;
            in_tog[cur_idx] <= ~in_tog[cur_idx];
            state           <= IDLE;
          end else if (rx_event || expired) begin
            in_retry <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_req_o      = tx_req;
  assign bus.tx_pid_o      = tx_pid;
  assign bus.tx_endp_o     = tx_endp;
  assign bus.endp_o        = endp;
  assign bus.in_ack_o      = in_ack;
  assign bus.in_retry_o    = in_retry;
  assign bus.out_commit_o  = out_commit;
  assign bus.out_discard_o = out_discard;
  assign bus.setup_o       = setup;

endmodule

// File: tb/tb_usb_trans_ctrl.sv
// Testbench for usb_trans_ctrl: a vector table of complete transactions, each
// pushing its expected transmitter requests and buffer strobes into a queue
// that a negedge monitor pops as the DUT produces them, plus hand-written
// sequences for timeout latency and reset in the middle of a transaction.
module tb_usb_trans_ctrl;

  localparam int N_ENDP      = 4;
  localparam int TIMEOUT_CYC = 72;

  localparam logic [3:0] P_OUT   = 4'h1;
  localparam logic [3:0] P_IN    = 4'h9;
  localparam logic [3:0] P_SOF   = 4'h5;
  localparam logic [3:0] P_SETUP = 4'hD;
  localparam logic [3:0] P_D0    = 4'h3;
  localparam logic [3:0] P_D1    = 4'hB;
  localparam logic [3:0] P_ACK   = 4'h2;
  localparam logic [3:0] P_NAK   = 4'hA;
  localparam logic [3:0] P_STALL = 4'hE;
  localparam logic [3:0] H_ERR   = 4'hF;  // host reply: corrupted packet

  typedef enum {EV_NONE, EV_TX, EV_IN_ACK, EV_IN_RETRY, EV_COMMIT,
                EV_DISCARD, EV_SETUP, EV_STRAY} ev_kind_e;

  typedef struct {
    ev_kind_e   kind;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    logic [3:0] tok;
    logic [6:0] addr;
    logic [3:0] ep;
    logic [3:0] data;      // packet after OUT/SETUP token, 0 = none
    logic       data_err;  // send rx_err_i instead of a data packet
    logic [3:0] in_rdy;
    logic [3:0] out_rdy;
    logic [3:0] stall;
    logic [3:0] host;      // reply after DATAx: 0 silence, H_ERR error, else PID
    logic [3:0] exp_tx;    // 0 = no transmission expected
    ev_kind_e   exp_pulse;
    int         idle;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  ev_t  exp_q[$];
  vec_t vecs[$];

  usb_trans_ctrl_if #(.N_ENDP(N_ENDP)) bus ();

  usb_trans_ctrl #(
    .N_ENDP     (N_ENDP),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind, input logic [7:0] val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got %s val=%0h expected nothing", kind.name(), val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL event_order: got %s val=%0h expected %s val=%0h",
                 kind.name(), val, e.kind.name(), e.val);
      end
    end
  endtask

  // Monitor: turn DUT strobes and transmit-request rises into scoreboard events.
  logic       prev_req = 1'b0;
  logic [3:0] cap_pid  = 4'h0;
  always @(negedge clk) begin
    if (bus.in_ack_o)      observe(EV_IN_ACK,   {4'h0, bus.endp_o});
    if (bus.in_retry_o)    observe(EV_IN_RETRY, {4'h0, bus.endp_o});
    if (bus.out_commit_o)  observe(bus.setup_o ? EV_SETUP : EV_COMMIT, {4'h0, bus.endp_o});
    else if (bus.setup_o)  observe(EV_STRAY,    {4'h0, bus.endp_o});
    if (bus.out_discard_o) observe(EV_DISCARD,  {4'h0, bus.endp_o});
    if (bus.tx_req_o && !prev_req) begin
      observe(EV_TX, (bus.tx_pid_o == P_D0 || bus.tx_pid_o == P_D1)
                     ? {bus.tx_endp_o, bus.tx_pid_o} : {4'h0, bus.tx_pid_o});
      cap_pid = bus.tx_pid_o;
    end else if (bus.tx_req_o) begin
      check("tx_pid_hold", {28'h0, bus.tx_pid_o}, {28'h0, cap_pid});
    end
    prev_req = bus.tx_req_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    bus.rx_valid_i = 1'b1;
    bus.rx_pid_i   = pid;
    bus.rx_addr_i  = addr;
    bus.rx_endp_i  = ep;
    tick();
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_err();
    bus.rx_err_i = 1'b1;
    tick();
    bus.rx_err_i = 1'b0;
  endtask

  // Behave as the transmitter: wait (bounded) for a request, hold, then finish.
  task automatic serve_tx();
    int n = 0;
    while (!bus.tx_req_o && n < 200) begin
      tick();
      n++;
    end
    check("tx_req_seen", {31'h0, bus.tx_req_o}, 32'h1);
    if (bus.tx_req_o) begin
      repeat (3) tick();
      bus.tx_done_i = 1'b1;
      tick();
      bus.tx_done_i = 1'b0;
      check("tx_req_drop", {31'h0, bus.tx_req_o}, 32'h0);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] tok, input logic [6:0] addr,
                              input logic [3:0] ep, input logic [3:0] data,
                              input logic data_err, input logic [3:0] in_rdy,
                              input logic [3:0] out_rdy, input logic [3:0] stall,
                              input logic [3:0] host, input logic [3:0] exp_tx,
                              input ev_kind_e exp_pulse, input int idle);
    vec_t v;
    v.tok = tok;   v.addr = addr;       v.ep = ep;           v.data = data;
    v.data_err = data_err;              v.in_rdy = in_rdy;   v.out_rdy = out_rdy;
    v.stall = stall; v.host = host;     v.exp_tx = exp_tx;   v.exp_pulse = exp_pulse;
    v.idle = idle;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [7:0] tx_val;
    logic       is_data_tx;
    is_data_tx        = (v.exp_tx == P_D0 || v.exp_tx == P_D1);
    tx_val            = is_data_tx ? {v.ep, v.exp_tx} : {4'h0, v.exp_tx};
    bus.in_ready_i    = v.in_rdy;
    bus.out_ready_i   = v.out_rdy;
    bus.stall_i       = v.stall;
    if (v.tok == P_IN) begin
      if (v.exp_tx != 4'h0)        push(EV_TX, tx_val);
      if (v.exp_pulse != EV_NONE)  push(v.exp_pulse, {4'h0, v.ep});
    end else begin
      if (v.exp_pulse != EV_NONE)  push(v.exp_pulse, {4'h0, v.ep});
      if (v.exp_tx != 4'h0)        push(EV_TX, tx_val);
    end
    send_pkt(v.tok, v.addr, v.ep);
    if (v.tok != P_IN) begin
      repeat (2) tick();
      if (v.data_err)           send_err();
      else if (v.data != 4'h0)  send_pkt(v.data, v.addr, v.ep);
    end
    if (v.exp_tx != 4'h0) serve_tx();
    if (v.tok == P_IN && is_data_tx) begin
      repeat (2) tick();
      if (v.host == H_ERR)      send_err();
      else if (v.host != 4'h0)  send_pkt(v.host, 7'd0, 4'd0);
    end
    repeat (v.idle) tick();
  endtask

  initial begin
    int cnt;
    bus.dev_addr_i  = 7'd5;
    bus.rx_valid_i  = 1'b0;
    bus.rx_err_i    = 1'b0;
    bus.rx_pid_i    = 4'h0;
    bus.rx_addr_i   = 7'd0;
    bus.rx_endp_i   = 4'd0;
    bus.in_ready_i  = 4'hF;
    bus.out_ready_i = 4'hF;
    bus.stall_i     = 4'h0;
    bus.tx_done_i   = 1'b0;

    //       tok      adr ep data  er in_rdy   out_rdy  stall    host   exp_tx   pulse        idle
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    P_ACK, P_D0,    EV_IN_ACK,   4));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    P_ACK, P_D1,    EV_IN_ACK,   4));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  P_D0,    EV_IN_RETRY, 90));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    P_ACK, P_D0,    EV_IN_ACK,   4));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'b0010, 4'h0,  P_STALL, EV_NONE,     4));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'b1101, 4'hF,    4'h0,    4'h0,  P_NAK,   EV_NONE,     4));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    H_ERR, P_D1,    EV_IN_RETRY, 4));
    vecs.push_back(mk(P_IN,    5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    P_NAK, P_D1,    EV_IN_RETRY, 4));
    vecs.push_back(mk(P_OUT,   5, 2, P_D0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  P_ACK,   EV_COMMIT,   4));
    vecs.push_back(mk(P_OUT,   5, 2, P_D0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  P_ACK,   EV_DISCARD,  4));
    vecs.push_back(mk(P_OUT,   5, 2, P_D1, 0, 4'hF,    4'hF,    4'h0,    4'h0,  P_ACK,   EV_COMMIT,   4));
    vecs.push_back(mk(P_OUT,   5, 2, P_D0, 0, 4'hF,    4'b1011, 4'h0,    4'h0,  P_NAK,   EV_DISCARD,  4));
    vecs.push_back(mk(P_OUT,   5, 2, P_D0, 0, 4'hF,    4'hF,    4'b0100, 4'h0,  P_STALL, EV_DISCARD,  4));
    vecs.push_back(mk(P_SETUP, 5, 0, P_D0, 0, 4'hF,    4'hF,    4'b0001, 4'h0,  P_ACK,   EV_SETUP,    4));
    vecs.push_back(mk(P_IN,    5, 0, 4'h0, 0, 4'hF,    4'hF,    4'h0,    P_ACK, P_D1,    EV_IN_ACK,   4));
    vecs.push_back(mk(P_OUT,   5, 0, P_D1, 0, 4'hF,    4'hF,    4'h0,    4'h0,  P_ACK,   EV_COMMIT,   4));
    vecs.push_back(mk(P_IN,    6, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_NONE,     6));
    vecs.push_back(mk(P_IN,    5, 4, 4'h0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_NONE,     6));
    vecs.push_back(mk(P_SOF,   5, 1, 4'h0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_NONE,     6));
    vecs.push_back(mk(P_OUT,   5, 2, 4'h0, 1, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_DISCARD,  4));
    vecs.push_back(mk(P_OUT,   5, 2, 4'h0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_DISCARD,  90));
    vecs.push_back(mk(P_OUT,   5, 2, P_IN, 0, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_DISCARD,  6));
    vecs.push_back(mk(P_IN,    5, 3, 4'h0, 0, 4'hF,    4'hF,    4'h0,    P_ACK, P_D0,    EV_IN_ACK,   4));
    vecs.push_back(mk(P_OUT,   6, 1, P_D0, 0, 4'hF,    4'hF,    4'h0,    4'h0,  4'h0,    EV_NONE,     6));

    // Reset state, sampled while reset is still held.
    repeat (3) tick();
    check("rst_tx_req",      {31'h0, bus.tx_req_o},      32'h0);
    check("rst_tx_pid",      {28'h0, bus.tx_pid_o},      32'h0);
    check("rst_endp",        {28'h0, bus.endp_o},        32'h0);
    check("rst_in_ack",      {31'h0, bus.in_ack_o},      32'h0);
    check("rst_in_retry",    {31'h0, bus.in_retry_o},    32'h0);
    check("rst_out_commit",  {31'h0, bus.out_commit_o},  32'h0);
    check("rst_out_discard", {31'h0, bus.out_discard_o}, 32'h0);
    check("rst_setup",       {31'h0, bus.setup_o},       32'h0);
    rst = 1'b0;
    repeat (2) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // IN timeout latency: ep1 toggle is 1 here, so DATA1 goes out and the
    // retry must appear about TIMEOUT_CYC cycles after the transmit finishes.
    bus.in_ready_i = 4'hF;
    bus.stall_i    = 4'h0;
    push(EV_TX, {4'h1, P_D1});
    push(EV_IN_RETRY, 8'h01);
    send_pkt(P_IN, 7'd5, 4'd1);
    serve_tx();
    cnt = 0;
    while (!bus.in_retry_o && cnt < 200) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt < TIMEOUT_CYC || cnt > TIMEOUT_CYC + 2) begin
      bad++;
      $display("FAIL retry_latency: got %0d cycles expected %0d..%0d",
               cnt, TIMEOUT_CYC, TIMEOUT_CYC + 2);
    end
    repeat (4) tick();

    // Reset while DATA1 is being requested: request drops, no strobes,
    // toggles cleared so the next IN on ep1 sends DATA0.
    push(EV_TX, {4'h1, P_D1});
    send_pkt(P_IN, 7'd5, 4'd1);
    check("pre_rst_tx_req", {31'h0, bus.tx_req_o}, 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_tx_req", {31'h0, bus.tx_req_o}, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    run_vec(mk(P_IN, 5, 1, 4'h0, 0, 4'hF, 4'hF, 4'h0, P_ACK, P_D0, EV_IN_ACK, 4));
    run_vec(mk(P_OUT, 5, 2, P_D0, 0, 4'hF, 4'hF, 4'h0, 4'h0, P_ACK, EV_COMMIT, 4));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending events expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
